// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: tracks the prefetch pointer, issues code fetches to the
// bus control unit and keeps returned bytes in an 8-byte circular buffer.
module prefetch_queue #(
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  ce_1,
  input  logic                  ce_2,
  input  logic                  reset,
  input  logic                  pfp_set,
  input  logic [15:0]           new_pfp,
  input  logic [15:0]           ipq_head,
  output logic [DEPTH-1:0][7:0] ipq,
  output logic [3:0]            ipq_len,
  output logic                  fetch_req,
  output logic [15:0]           fetch_addr,
  output logic                  fetch_wide,
  input  logic                  fetch_ack,
  input  logic [15:0]           fetch_data,
  output logic                  fault
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t           state_q, state_d;
  logic [15:0]      pfp_q, pfp_d;
  logic             fetch_req_q, fetch_req_d;
  logic             fetch_wide_q, fetch_wide_d;
  logic             fault_q, fault_d;
  logic             en;
  logic             wr_en;
  logic [15:0]      diff;
  logic             len_ok;
  logic [IDX_W-1:0] wr_idx, wr_idx_hi;

  assign en        = ce_1 | ce_2;
  assign diff      = pfp_q - ipq_head;
  assign len_ok    = (diff <= 16'd8);
  assign ipq_len   = len_ok ? diff[3:0] : 4'd0;
  assign wr_idx    = pfp_q[IDX_W-1:0];
  assign wr_idx_hi = wr_idx + IDX_W'(1);

  assign fetch_req  = fetch_req_q;
  assign fetch_addr = pfp_q;
  assign fetch_wide = fetch_wide_q;
  assign fault      = fault_q;

  always_comb begin
    state_d      = state_q;
    pfp_d        = pfp_q;
    fetch_req_d  = fetch_req_q;
    fetch_wide_d = fetch_wide_q;
    fault_d      = fault_q;
    wr_en        = 1'b0;
    if (en) begin
      // A flush edge reloads PFP, so the stale length is not treated as an error there.
      if (!len_ok && !pfp_set) begin
        fault_d = 1'b1;
      end
      if (fetch_ack && state_q == IDLE) begin
        fault_d = 1'b1;
      end
      if (pfp_set) begin
        pfp_d = new_pfp;
        case (state_q)
          WAIT: begin
            if (fetch_ack) begin
              state_d     = IDLE;
              fetch_req_d = 1'b0;
            end else begin
              state_d = DISCARD;
            end
          end
          DISCARD: begin
            if (fetch_ack) begin
              state_d     = IDLE;
              fetch_req_d = 1'b0;
            end
          end
          default: state_d = IDLE;
        endcase
      end else begin
        case (state_q)
          IDLE: begin
            if (ipq_len <= 4'd6 && !pfp_q[0]) begin
              state_d      = WAIT;
              fetch_req_d  = 1'b1;
              fetch_wide_d = 1'b1;
            end else if (ipq_len <= 4'd7 && pfp_q[0]) begin
              state_d      = WAIT;
              fetch_req_d  = 1'b1;
              fetch_wide_d = 1'b0;
            end
          end
          WAIT: begin
            if (fetch_ack) begin
              wr_en       = 1'b1;
              pfp_d       = pfp_q + (fetch_wide_q ? 16'd2 : 16'd1);
              state_d     = IDLE;
              fetch_req_d = 1'b0;
            end
          end
          DISCARD: begin
            if (fetch_ack) begin
              state_d     = IDLE;
              fetch_req_d = 1'b0;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pfp_q        <= 16'h0000;
      fetch_req_q  <= 1'b0;
      fetch_wide_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pfp_q        <= pfp_d;
      fetch_req_q  <= fetch_req_d;
      fetch_wide_q <= fetch_wide_d;
      fault_q      <= fault_d;
    end
  end

  // Byte fetches at odd addresses return their byte on the upper data lane.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_lane
      logic [7:0] byte_q, byte_d;

      always_comb begin
        byte_d = byte_q;
        if (wr_en && wr_idx == IDX_W'(gi)) begin
          byte_d = fetch_wide_q ? fetch_data[7:0] : fetch_data[15:8];
        end else if (wr_en && fetch_wide_q && wr_idx_hi == IDX_W'(gi)) begin
          byte_d = fetch_data[15:8];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          byte_q <= 8'h00;
        end else begin
          byte_q <= byte_d;
        end
      end

      assign ipq[gi] = byte_q;
    end
  endgenerate

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue: a vector table for sequential fetch/fill behaviour,
// then hand-written sequences for head advance, flushes, wrap and protocol errors.
module tb_prefetch_queue;

  logic            clk = 1'b0;
  logic            ce_1, ce_2, reset, pfp_set, fetch_ack;
  logic [15:0]     new_pfp, ipq_head, fetch_data;
  logic [7:0][7:0] ipq;
  logic [3:0]      ipq_len;
  logic            fetch_req, fetch_wide, fault;
  logic [15:0]     fetch_addr;

  int n_pass  = 0;
  int n_total = 0;

  prefetch_queue #(.DEPTH(8)) dut (
    .clk(clk), .ce_1(ce_1), .ce_2(ce_2), .reset(reset),
    .pfp_set(pfp_set), .new_pfp(new_pfp), .ipq_head(ipq_head),
    .ipq(ipq), .ipq_len(ipq_len),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_wide(fetch_wide),
    .fetch_ack(fetch_ack), .fetch_data(fetch_data), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pset;
    logic [15:0] npfp;
    logic [15:0] head;
    logic        ack;
    logic [15:0] data;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_wide;
    logic [3:0]  e_len;
  } vec_t;

  vec_t vecs [20];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic chk_req(input string name, input logic [15:0] addr, input logic wide);
    chk({name, ".req"}, 32'(fetch_req), 32'd1);
    chk({name, ".addr"}, 32'(fetch_addr), 32'(addr));
    chk({name, ".wide"}, 32'(fetch_wide), 32'(wide));
  endtask

  initial begin
    ce_1 = 1'b1; ce_2 = 1'b0; reset = 1'b1; pfp_set = 1'b0; fetch_ack = 1'b0;
    new_pfp = 16'h0; ipq_head = 16'h0; fetch_data = 16'h0;

    //            pset  npfp      head      ack   data      req   addr      wide  len
    vecs[0]  = '{1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'd0};
    vecs[1]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 4'd0};
    vecs[2]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1100, 1'b0, 16'h0000, 1'b0, 4'd2};
    vecs[3]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 4'd2};
    vecs[4]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1101, 1'b0, 16'h0000, 1'b0, 4'd4};
    vecs[5]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 4'd4};
    vecs[6]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1102, 1'b0, 16'h0000, 1'b0, 4'd6};
    vecs[7]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0006, 1'b1, 4'd6};
    vecs[8]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1103, 1'b0, 16'h0000, 1'b0, 4'd8};
    vecs[9]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'd8};
    vecs[10] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'd8};
    vecs[11] = '{1'b1, 16'h0101, 16'h0101, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'd0};
    vecs[12] = '{1'b0, 16'h0000, 16'h0101, 1'b0, 16'h0000, 1'b1, 16'h0101, 1'b0, 4'd0};
    vecs[13] = '{1'b0, 16'h0000, 16'h0101, 1'b1, 16'hAB00, 1'b0, 16'h0000, 1'b0, 4'd1};
    vecs[14] = '{1'b0, 16'h0000, 16'h0101, 1'b0, 16'h0000, 1'b1, 16'h0102, 1'b1, 4'd1};
    vecs[15] = '{1'b0, 16'h0000, 16'h0101, 1'b1, 16'h3322, 1'b0, 16'h0000, 1'b0, 4'd3};
    vecs[16] = '{1'b0, 16'h0000, 16'h0101, 1'b0, 16'h0000, 1'b1, 16'h0104, 1'b1, 4'd3};
    vecs[17] = '{1'b0, 16'h0000, 16'h0101, 1'b1, 16'h5544, 1'b0, 16'h0000, 1'b0, 4'd5};
    vecs[18] = '{1'b0, 16'h0000, 16'h0101, 1'b0, 16'h0000, 1'b1, 16'h0106, 1'b1, 4'd5};
    vecs[19] = '{1'b0, 16'h0000, 16'h0101, 1'b1, 16'h7766, 1'b0, 16'h0000, 1'b0, 4'd7};

    // Reset state
    tick();
    reset = 1'b0;
    chk("rst.req", 32'(fetch_req), 32'd0);
    chk("rst.len", 32'(ipq_len), 32'd0);
    chk("rst.fault", 32'(fault), 32'd0);
    chk("rst.addr", 32'(fetch_addr), 32'd0);
    chk("rst.ipq0", 32'(ipq[0]), 32'd0);

    // Table: fill from 0000, then flush to odd 0101 and refill
    for (int i = 0; i < 20; i++) begin
      pfp_set    = vecs[i].pset;
      new_pfp    = vecs[i].npfp;
      ipq_head   = vecs[i].head;
      fetch_ack  = vecs[i].ack;
      fetch_data = vecs[i].data;
      tick();
      chk($sformatf("vec%0d.req", i), 32'(fetch_req), 32'(vecs[i].e_req));
      chk($sformatf("vec%0d.len", i), 32'(ipq_len), 32'(vecs[i].e_len));
      chk($sformatf("vec%0d.fault", i), 32'(fault), 32'd0);
      if (vecs[i].e_req) begin
        chk($sformatf("vec%0d.addr", i), 32'(fetch_addr), 32'(vecs[i].e_addr));
        chk($sformatf("vec%0d.wide", i), 32'(fetch_wide), 32'(vecs[i].e_wide));
      end
      if (i == 10) begin
        chk("fill.ipq0", 32'(ipq[0]), 32'h00);
        chk("fill.ipq1", 32'(ipq[1]), 32'h11);
        chk("fill.ipq6", 32'(ipq[6]), 32'h03);
      end
      if (i == 13) chk("odd.ipq1", 32'(ipq[1]), 32'hAB);
      $display("vec %0d: req=%0b addr=%h wide=%0b len=%0d", i, fetch_req, fetch_addr, fetch_wide, ipq_len);
    end
    pfp_set = 1'b0; fetch_ack = 1'b0;

    // Full queue, then head advance by 3 frees slots combinationally
    ipq_head = 16'h0100;
    #1 chk("full.len", 32'(ipq_len), 32'd8);
    tick();
    chk("full.req", 32'(fetch_req), 32'd0);
    ipq_head = 16'h0103;
    #1 chk("adv.len", 32'(ipq_len), 32'd5);
    chk("adv.req_now", 32'(fetch_req), 32'd0);
    tick();
    chk_req("adv", 16'h0108, 1'b1);
    fetch_ack = 1'b1; fetch_data = 16'h9988;
    tick();
    fetch_ack = 1'b0;
    chk("adv.len2", 32'(ipq_len), 32'd7);
    chk("adv.ipq0", 32'(ipq[0]), 32'h88);
    chk("adv.ipq1", 32'(ipq[1]), 32'h99);
    $display("head advance: len=%0d ipq0=%h ipq1=%h", ipq_len, ipq[0], ipq[1]);

    // Flush while WAIT, ack two cycles later
    ipq_head = 16'h010A;
    tick();
    chk_req("pre_flush", 16'h010A, 1'b1);
    pfp_set = 1'b1; new_pfp = 16'h2000; ipq_head = 16'h2000;
    tick();
    pfp_set = 1'b0;
    chk("disc.req1", 32'(fetch_req), 32'd1);
    tick();
    chk("disc.req2", 32'(fetch_req), 32'd1);
    fetch_ack = 1'b1; fetch_data = 16'hFFFF;
    tick();
    fetch_ack = 1'b0;
    chk("disc.req_off", 32'(fetch_req), 32'd0);
    chk("disc.len", 32'(ipq_len), 32'd0);
    chk("disc.ipq0", 32'(ipq[0]), 32'h88);
    chk("disc.ipq2", 32'(ipq[2]), 32'h22);
    tick();
    chk_req("after_disc", 16'h2000, 1'b1);
    $display("flush in WAIT: req=%0b addr=%h len=%0d", fetch_req, fetch_addr, ipq_len);

    // Flush and ack on the same edge
    pfp_set = 1'b1; new_pfp = 16'h3000; ipq_head = 16'h3000;
    fetch_ack = 1'b1; fetch_data = 16'hFFFF;
    tick();
    pfp_set = 1'b0; fetch_ack = 1'b0;
    chk("same.req", 32'(fetch_req), 32'd0);
    chk("same.len", 32'(ipq_len), 32'd0);
    chk("same.ipq0", 32'(ipq[0]), 32'h88);
    tick();
    chk_req("after_same", 16'h3000, 1'b1);
    fetch_ack = 1'b1; fetch_data = 16'h1234;
    tick();
    fetch_ack = 1'b0;
    chk("same.len2", 32'(ipq_len), 32'd2);
    chk("same.ipq0b", 32'(ipq[0]), 32'h34);
    chk("same.ipq1b", 32'(ipq[1]), 32'h12);
    $display("flush+ack same edge: len=%0d ipq0=%h", ipq_len, ipq[0]);

    // Wrap at FFFE, with clock-enable gating
    pfp_set = 1'b1; new_pfp = 16'hFFFE; ipq_head = 16'hFFFE;
    tick();
    pfp_set = 1'b0;
    chk("wrap.req0", 32'(fetch_req), 32'd0);
    ce_1 = 1'b0; ce_2 = 1'b0;
    tick();
    chk("ce_off.req", 32'(fetch_req), 32'd0);
    ce_2 = 1'b1;
    tick();
    ce_1 = 1'b1; ce_2 = 1'b0;
    chk_req("wrap", 16'hFFFE, 1'b1);
    fetch_ack = 1'b1; fetch_data = 16'hBEEF;
    tick();
    fetch_ack = 1'b0;
    chk("wrap.len", 32'(ipq_len), 32'd2);
    chk("wrap.ipq6", 32'(ipq[6]), 32'hEF);
    chk("wrap.ipq7", 32'(ipq[7]), 32'hBE);
    tick();
    chk_req("wrap_next", 16'h0000, 1'b1);
    $display("wrap: addr=%h len=%0d", fetch_addr, ipq_len);

    // Ack while IDLE
    fetch_ack = 1'b1; fetch_data = 16'h0000;
    tick();
    chk("idle.len_pre", 32'(ipq_len), 32'd4);
    fetch_data = 16'h5A5A;
    tick();
    fetch_ack = 1'b0;
    chk("idle_ack.fault", 32'(fault), 32'd1);
    chk("idle_ack.len", 32'(ipq_len), 32'd4);
    chk("idle_ack.ipq2", 32'(ipq[2]), 32'h22);
    tick();
    chk("sticky.fault", 32'(fault), 32'd1);
    $display("ack in IDLE: fault=%0b len=%0d", fault, ipq_len);

    // Reset mid-fetch clears request and fault
    reset = 1'b1; ipq_head = 16'h0000;
    tick();
    reset = 1'b0;
    chk("rst2.req", 32'(fetch_req), 32'd0);
    chk("rst2.fault", 32'(fault), 32'd0);
    chk("rst2.ipq2", 32'(ipq[2]), 32'h00);

    // Head ahead of PFP
    ipq_head = 16'h0001;
    #1 chk("ahead.len", 32'(ipq_len), 32'd0);
    tick();
    chk("ahead.fault", 32'(fault), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst3.fault", 32'(fault), 32'd0);
    $display("head ahead + reset: fault=%0b", fault);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/prefetch_queue.md
# prefetch_queue

Instruction prefetch queue for the V33 core. It tracks the prefetch pointer (PFP) within the PS segment and issues code-fetch requests to the bus control unit. It stores returned bytes in an 8-byte circular buffer and presents them, with a valid length, to the pre-decode and execute stages. Those stages consume bytes by advancing the head pointer (`reg_pc`). A flush (`pfp_set`) discards all queued and in-flight bytes and restarts fetching at a new offset.

## Interface
Parameters:
- `DEPTH`, 8: queue size in bytes; fixed at 8 (index width 3).

Ports:
- `clk`  in  1  core clock.
- `ce_1`  in  1  phase-1 clock enable.
- `ce_2`  in  1  phase-2 clock enable.
- `reset`  in  1  synchronous, active-high reset.
- `pfp_set`  in  1  flush; load PFP from `new_pfp`.
- `new_pfp`  in  16  restart offset within PS.
- `ipq_head`  in  16  consumer head pointer (`reg_pc`); the consumer advances it.
- `ipq`  out  8x8  buffer bytes; the byte at offset `a` is held in `ipq[a[2:0]]`.
- `ipq_len`  out  4  valid bytes from `ipq_head`, 0..8.
- `fetch_req`  out  1  code-fetch request (level).
- `fetch_addr`  out  16  PS offset of the request (equals PFP).
- `fetch_wide`  out  1  1 = 16-bit fetch (even address), 0 = byte fetch (odd address).
- `fetch_ack`  in  1  fetch complete; `fetch_data` valid.
- `fetch_data`  in  16  returned data, little-endian. For a byte fetch at an odd address the byte is on [15:8].
- `fault`  out  1  sticky protocol-error flag.

## Operation
- State updates occur only on `clk` edges with `ce_1|ce_2`; inputs are sampled on those edges only.
- **Length:**
  - `diff = PFP - ipq_head` (16-bit, modulo 2^16).
  - `ipq_len = diff[3:0]` if `diff <= 8`, else 0, and `fault` is set.
  - `ipq_len` is combinational from registered PFP and the live `ipq_head`.
- **State machine:**
  - `IDLE`: no fetch outstanding.
    - If `len <= 6` and PFP is even: raise `fetch_req` with `fetch_wide=1`; go to `WAIT`.
    - Else if `len <= 7` and PFP is odd: raise `fetch_req` with `fetch_wide=0`; go to `WAIT`.
  - `WAIT`: `fetch_req=1`; `fetch_addr` and `fetch_wide` are held stable.
    - On `fetch_ack`, wide fetch: write `data[7:0]` to `ipq[PFP[2:0]]` and `data[15:8]` to `ipq[PFP[2:0]+1]`; PFP += 2.
    - On `fetch_ack`, byte fetch: write `data[15:8]` to `ipq[PFP[2:0]]`; PFP += 1.
    - Then go to `IDLE`.
  - `DISCARD`: fetch outstanding after a flush; `fetch_req` stays 1. On `fetch_ack`, drop the data and go to `IDLE`.
- **Flush** (`pfp_set`; takes priority over everything except `reset`):
  - PFP <= `new_pfp`.
  - `IDLE`: stay in `IDLE`.
  - `WAIT` without ack: go to `DISCARD`.
  - `WAIT` or `DISCARD` with ack on the same edge: drop the data; go to `IDLE`.
  - Buffer contents are not cleared; they are invalid because of the length arithmetic.
- **Wrap:**
  - PFP wraps FFFF->0000 with no special handling.
  - A wide fetch is never issued at FFFF, because FFFF is odd.
- **Errors:**
  - `fetch_ack` in `IDLE` is ignored and sets `fault`.
  - `fault` clears only on `reset`.
- **Reset values:** PFP=0, state `IDLE`, `fetch_req=0`, `fetch_addr=0`, `fetch_wide=0`, `ipq` all 00, `fault=0`.

## Timing
- `fetch_req` rises on the enabled edge after the `IDLE` conditions hold.
- `fetch_req` drops on the same edge that samples `fetch_ack`.
- After that edge, `fetch_req` stays low for at least one enabled cycle before re-request; back-to-back requests are spaced by 1 enabled cycle.
- Enqueued bytes are visible in `ipq` and `ipq_len` immediately after the ack edge.
- Head advance reduces `ipq_len` combinationally; a freed slot can trigger a request on the next enabled edge.
- **Simultaneous ack and head advance:** PFP and `ipq_head` both move; `len` reflects both.
- **Reset mid-fetch:** the request is dropped and state is `IDLE`. The BCU must also be reset; a late ack sets `fault`.
- At most one fetch is outstanding at any time.

## Test plan
1. **Reset, then flush to 0x0000 and ack each request with `data=0x1100+n`:**
   - Requests are wide at 0000, 0002, 0004, 0006.
   - `ipq_len` is then 8 and `fetch_req` stays 0.
   - `ipq[0]=00`, `ipq[1]=11`.
2. **Flush to 0x0101:**
   - First request: addr 0101, `wide=0`; ack `data=0xAB00` gives `ipq[1]=AB`, `len=1`.
   - Next request: addr 0102, `wide=1`.
3. **Queue full (`len=8`), then head +3:**
   - `len=5` at once.
   - A request is issued on the next enabled edge (PFP even, len ≤ 6).
4. **Flush to 0x2000 while in `WAIT`, ack 2 cycles later:**
   - The data is dropped and `len` stays 0.
   - The next request is at 2000.
   - Repeat with flush and ack on the same edge: same result.
5. **PFP=FFFE, head=FFFE:**
   - Wide fetch at FFFE; after ack, PFP=0000 and `len=2`.
   - The next request is at 0000.
6. **Protocol errors:**
   - Ack while `IDLE`: `fault=1`, queue unchanged.
   - Head set to PFP+1: `ipq_len=0`, `fault=1`.
   - `reset` clears `fault`.
